// File: rtl/data_break_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : data_break_ctrl
// Purpose  : Single-word DMA data-break sequencer between a disk controller
//            and the CPU major-state machine (DB1/DB2 cycle stealing).
// Revision : 1.0 - initial release
// ============================================================================
module data_break_ctrl #(
    parameter int         TIMEOUT = 1023,
    parameter logic [4:0] DB1     = 5'd6,
    parameter logic [4:0] DB2     = 5'd7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic [4:0]  state,
    input  logic        dma_req,
    input  logic        dma_rd,
    input  logic        dma_wr,
    input  logic [0:14] dma_addr,
    input  logic [0:11] dma_dout,
    input  logic [0:11] mem_rdata,
    output logic        dma_gnt,
    output logic [0:11] dma_din,
    output logic        data_break,
    output logic [0:14] break_addr,
    output logic [0:11] break_data,
    output logic        to_mem,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        ACTIVE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [9:0] c_timeout = 10'(TIMEOUT);

    state_t      r_state;
    logic [9:0]  r_cnt;
    logic        r_gnt;
    logic [0:11] r_din;
    logic        r_break;
    logic [0:14] r_addr;
    logic [0:11] r_data;
    logic        r_to_mem;
    logic        r_busy;
    logic        r_err;

    logic [9:0]  w_cnt_inc;

    assign w_cnt_inc = r_cnt + 10'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= 10'd0;
            r_gnt    <= 1'b0;
            r_din    <= 12'o0000;
            r_break  <= 1'b0;
            r_addr   <= 15'o00000;
            r_data   <= 12'o0000;
            r_to_mem <= 1'b0;
            r_busy   <= 1'b0;
            r_err    <= 1'b0;
        end else if (clear) begin
            r_state  <= IDLE;
            r_cnt    <= 10'd0;
            r_gnt    <= 1'b0;
            r_din    <= 12'o0000;
            r_break  <= 1'b0;
            r_addr   <= 15'o00000;
            r_data   <= 12'o0000;
            r_to_mem <= 1'b0;
            r_busy   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_gnt <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (dma_req) begin
                        if (dma_rd ^ dma_wr) begin
                            r_addr   <= dma_addr;
                            r_data   <= dma_dout;
                            r_to_mem <= dma_wr;
                            r_break  <= 1'b1;
                            r_cnt    <= 10'd0;
                            r_busy   <= 1'b1;
                            r_state  <= REQ;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                REQ, ACTIVE: begin
                    r_cnt <= w_cnt_inc;
                    // DB2 wins over timeout: the word has actually moved.
                    if (state == DB2) begin
                        if (!r_to_mem) begin
                            r_din <= mem_rdata;
                        end
                        r_break <= 1'b0;
                        r_gnt   <= 1'b1;
                        r_state <= DONE;
                    end else if (w_cnt_inc == c_timeout) begin
                        r_din   <= 12'o0000;
                        r_break <= 1'b0;
                        r_err   <= 1'b1;
                        r_gnt   <= 1'b1;
                        r_state <= DONE;
                    end else if (r_state == REQ && state == DB1) begin
                        r_state <= ACTIVE;
                    end
                end
                DONE: begin
                    if (!dma_req) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign dma_gnt    = r_gnt;
    assign dma_din    = r_din;
    assign data_break = r_break;
    assign break_addr = r_addr;
    assign break_data = r_data;
    assign to_mem     = r_to_mem;
    assign busy       = r_busy;
    assign err        = r_err;

endmodule
`default_nettype wire

// File: doc/data_break_ctrl.md
DATA_BREAK_CTRL -- requirements
Module: data_break_ctrl

Interface
REQ-001 Parameter: TIMEOUT, 1023, cycles allowed from request to DB2 before abort (range 2..1023, 10-bit counter).
REQ-002 clk  in  1  system clock; all logic on posedge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 clear  in  1  synchronous IOCLR; same effect as reset, applied on the clock edge.
REQ-005 state  in  5  CPU major state; compared against project parameters DB1, DB2.
REQ-006 dma_req  in  1  disk controller requests one word transfer.
REQ-007 dma_rd  in  1  transfer is memory-to-disk (qualifies dma_req).
REQ-008 dma_wr  in  1  transfer is disk-to-memory (qualifies dma_req).
REQ-009 dma_addr  in  [0:14]  15-bit memory address (field + word).
REQ-010 dma_dout  in  [0:11]  word from disk to memory.
REQ-011 mem_rdata  in  [0:11]  memory word presented by CPU during DB2.
REQ-012 dma_gnt  out  1  one-cycle completion pulse to disk controller.
REQ-013 dma_din  out  [0:11]  word read from memory, valid from dma_gnt onward.
REQ-014 data_break  out  1  break request to CPU.
REQ-015 break_addr  out  [0:14]  registered address for CPU.
REQ-016 break_data  out  [0:11]  registered write data for CPU.
REQ-017 to_mem  out  1  1 = write memory, 0 = read memory.
REQ-018 busy  out  1  high in any state except IDLE.
REQ-019 err  out  1  sticky: timeout or illegal request.

Function
REQ-020 FSM states IDLE, REQ, ACTIVE, DONE; all outputs registered.
REQ-021 IDLE: dma_req=1 with exactly one of dma_rd/dma_wr -> latch dma_addr to break_addr, dma_dout to break_data, dma_wr to to_mem; set data_break; clear counter; go REQ next cycle.
REQ-022 IDLE: dma_req=1 with dma_rd=dma_wr (both or neither) -> set err, stay IDLE, no data_break, no grant.
REQ-023 REQ: state==DB1 -> ACTIVE; break_addr/break_data/to_mem held constant.
REQ-024 ACTIVE: state==DB2 -> if to_mem=0 capture mem_rdata into dma_din; clear data_break; go DONE.
REQ-025 State==DB2 observed while in REQ (DB1 missed) is treated as ACTIVE->DB2 in the same cycle.
REQ-026 DONE: dma_gnt=1 for exactly the first cycle in DONE; remain in DONE until dma_req=0, then IDLE.
REQ-027 Timeout counter increments each cycle in REQ/ACTIVE; at count==TIMEOUT: clear data_break, set err, dma_din=0o0000, go DONE (grant still pulses).
REQ-028 Latency: dma_req to data_break = 1 cycle; DB2 to dma_gnt = 1 cycle.
REQ-029 dma_addr/dma_dout/dma_rd/dma_wr changes after acceptance are ignored until IDLE re-entered.
REQ-030 A new request is accepted no earlier than the cycle after returning to IDLE; no back-to-back grant without dma_req dropping.
REQ-031 err cleared only by reset/clear; err does not block further transfers.

Reset
REQ-032 reset (async) or clear (sync): state IDLE, data_break=0, dma_gnt=0, to_mem=0, busy=0, err=0, counter=0, break_addr=0o00000, break_data=0o0000, dma_din=0o0000.
REQ-033 clear during REQ/ACTIVE aborts the transfer with no dma_gnt pulse; data_break low the following cycle.

Verification
REQ-034 Write: dma_req=1, dma_wr=1, addr=0o12345, dout=0o7070; state DB1 then DB2 -> break_addr=0o12345, break_data=0o7070, to_mem=1, one dma_gnt pulse one cycle after DB2, err=0.
REQ-035 Read: dma_rd=1, addr=0o00200, mem_rdata=0o4321 at DB2 -> dma_din=0o4321 at grant, to_mem=0.
REQ-036 Timeout: TIMEOUT=8, request with state never DB1/DB2 -> data_break drops after 8 cycles, err=1, dma_din=0o0000, single grant.
REQ-037 Illegal: dma_req=1 with dma_rd=dma_wr=1 -> err=1, data_break stays 0, no grant, busy=0.
REQ-038 Abort: assert clear while in ACTIVE -> data_break=0, busy=0 next cycle, no grant; async reset mid-REQ clears outputs immediately.
REQ-039 Handshake: hold dma_req high 5 cycles after grant -> exactly one grant, FSM stays DONE until req drops.
